// File: rtl/uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_bridge
// Brief    : UART byte-stream to Wishbone master command bridge. Decodes
//            'W' A3..A0 D3..D0 and 'R' A3..A0 frames, runs one bus cycle and
//            returns 'K', the four read bytes or 'E' on ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_wb_bridge #(
  parameter int ACK_TIMEOUT = 255,
  parameter int FRAME_GAP   = 4000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam logic [2:0]  c_ST_IDLE = 3'd0;
  localparam logic [2:0]  c_ST_ADDR = 3'd1;
  localparam logic [2:0]  c_ST_DATA = 3'd2;
  localparam logic [2:0]  c_ST_WB   = 3'd3;
  localparam logic [2:0]  c_ST_RESP = 3'd4;

  localparam logic [7:0]  c_CMD_WR  = 8'h57;
  localparam logic [7:0]  c_CMD_RD  = 8'h52;
  localparam logic [7:0]  c_RSP_OK  = 8'h4B;
  localparam logic [7:0]  c_RSP_ERR = 8'h45;

  localparam logic [19:0] c_GAP_LIMIT = 20'(FRAME_GAP);
  localparam logic [15:0] c_ACK_LAST  = 16'(ACK_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_resp;       // response bytes, current byte in [31:24]
  logic [1:0]  r_byte_cnt;   // frame bytes accepted in ADDR/DATA
  logic [1:0]  r_tx_left;    // response bytes remaining after the current one
  logic [19:0] r_gap;
  logic [15:0] r_ack_tmr;
  logic        r_overrun;

  logic w_in_frame;
  logic w_gap_hit;
  logic w_is_cmd;
  logic w_restart;
  logic w_frame_byte;
  logic w_ack_hit;
  logic w_to_hit;
  logic w_tx_fire;

  assign w_in_frame   = (r_state == c_ST_ADDR) || (r_state == c_ST_DATA);
  assign w_gap_hit    = w_in_frame && (r_gap == c_GAP_LIMIT);
  assign w_is_cmd     = rx_valid && ((rx_data == c_CMD_WR) || (rx_data == c_CMD_RD));
  // A command byte landing on the gap-expiry cycle starts a fresh frame
  assign w_restart    = w_is_cmd && ((r_state == c_ST_IDLE) || w_gap_hit);
  assign w_frame_byte = rx_valid && w_in_frame && !w_gap_hit;
  // Ack on the final timeout edge still wins over the timeout
  assign w_ack_hit    = (r_state == c_ST_WB) && wbm_ack_i;
  assign w_to_hit     = (r_state == c_ST_WB) && !wbm_ack_i && (r_ack_tmr == c_ACK_LAST);
  assign w_tx_fire    = (r_state == c_ST_RESP) && tx_ready;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_restart) w_next = c_ST_ADDR;
      end
      c_ST_ADDR: begin
        if (w_gap_hit) begin
          w_next = w_restart ? c_ST_ADDR : c_ST_IDLE;
        end else if (w_frame_byte && (r_byte_cnt == 2'd3)) begin
          w_next = r_we ? c_ST_DATA : c_ST_WB;
        end
      end
      c_ST_DATA: begin
        if (w_gap_hit) begin
          w_next = w_restart ? c_ST_ADDR : c_ST_IDLE;
        end else if (w_frame_byte && (r_byte_cnt == 2'd3)) begin
          w_next = c_ST_WB;
        end
      end
      c_ST_WB: begin
        if (w_ack_hit || w_to_hit) w_next = c_ST_RESP;
      end
      c_ST_RESP: begin
        if (w_tx_fire && (r_tx_left == 2'd0)) w_next = c_ST_IDLE;
      end
      default: w_next = c_ST_IDLE;
    endcase
  end

  // Bus and transmitter handshake outputs decoded from the current state
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy_o    = (r_state != c_ST_IDLE);
    case (r_state)
      c_ST_WB: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = r_we;
        wbm_sel_o = 4'hF;
      end
      c_ST_RESP: begin
        tx_valid = 1'b1;
        tx_data  = r_resp[31:24];
      end
      default: begin
        wbm_cyc_o = 1'b0;
      end
    endcase
  end

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign overrun_o = r_overrun;

  // Frame assembly, timers, response capture and overrun flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we       <= 1'b0;
      r_adr      <= 32'h0;
      r_dat      <= 32'h0;
      r_resp     <= 32'h0;
      r_byte_cnt <= 2'd0;
      r_tx_left  <= 2'd0;
      r_gap      <= 20'd0;
      r_ack_tmr  <= 16'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= rx_valid && ((r_state == c_ST_WB) || (r_state == c_ST_RESP));

      if (w_restart) begin
        r_we       <= (rx_data == c_CMD_WR);
        r_byte_cnt <= 2'd0;
      end else if (w_frame_byte) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      if (w_frame_byte && (r_state == c_ST_ADDR)) r_adr <= {r_adr[23:0], rx_data};
      if (w_frame_byte && (r_state == c_ST_DATA)) r_dat <= {r_dat[23:0], rx_data};

      // Idle-cycle counter between frame bytes; restarts on every byte
      r_gap     <= (w_in_frame && !w_gap_hit && !rx_valid) ? r_gap + 20'd1 : 20'd0;
      r_ack_tmr <= ((r_state == c_ST_WB) && !wbm_ack_i) ? r_ack_tmr + 16'd1 : 16'd0;

      if (w_ack_hit) begin
        r_resp    <= r_we ? {c_RSP_OK, 24'h0} : wbm_dat_i;
        r_tx_left <= r_we ? 2'd0 : 2'd3;
      end else if (w_to_hit) begin
        r_resp    <= {c_RSP_ERR, 24'h0};
        r_tx_left <= 2'd0;
      end else if (w_tx_fire) begin
        r_resp    <= {r_resp[23:0], 8'h00};
        r_tx_left <= r_tx_left - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_wb_bridge
// Brief    : Scoreboard bench for uart_wb_bridge: randomized command frames,
//            behavioural memory model, Wishbone slave and UART sink monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_wb_bridge;

  localparam int ACK_TIMEOUT = 8;
  localparam int FRAME_GAP   = 16;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o;
  logic        overrun_o;

  uart_wb_bridge #(.ACK_TIMEOUT(ACK_TIMEOUT), .FRAME_GAP(FRAME_GAP)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // kind: 0 = slave acks after delay, 1 = slave silent (timeout), 2 = aborted by reset
  typedef struct {
    bit        we;
    bit [31:0] adr;
    bit [31:0] dat;
    int        kind;
    int        delay;
  } bus_exp_t;

  bus_exp_t  exp_bus[$];
  bit [7:0]  exp_tx[$];
  bit [31:0] model_mem [bit [31:0]];
  bit [31:0] slave_mem [bit [31:0]];

  int checks  = 0;
  int errors  = 0;
  int exp_ovr = 0;
  int obs_ovr = 0;
  int slave_delay = 0;
  bit slave_mute  = 1'b0;
  int tx_hold     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Content of a never-written slave location
  function automatic bit [31:0] dflt(input bit [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Wishbone slave plus bus-cycle monitor
  initial begin : slave_mon
    int       cnt;
    int       len;
    bit       have;
    bit       unstable;
    bus_exp_t cur;
    bit [31:0] a0;
    bit [31:0] d0;
    bit        we0;
    cnt = 0; len = 0; have = 1'b0; unstable = 1'b0;
    a0 = 32'h0; d0 = 32'h0; we0 = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o) begin
        if (len == 0) begin
          a0 = wbm_adr_o; d0 = wbm_dat_o; we0 = wbm_we_o;
          if (exp_bus.size() == 0) begin
            checks++; errors++; have = 1'b0;
            $display("FAIL unexpected_bus_cycle: got adr 0x%0h, expected no cycle", wbm_adr_o);
          end else begin
            cur  = exp_bus.pop_front();
            have = 1'b1;
            chk("bus_we", 32'(wbm_we_o), 32'(cur.we));
            chk("bus_adr", wbm_adr_o, cur.adr);
            if (cur.we) chk("bus_dat", wbm_dat_o, cur.dat);
            chk("bus_sel", 32'(wbm_sel_o), 32'hF);
          end
        end
        if ((wbm_adr_o !== a0) || (wbm_dat_o !== d0) || (wbm_we_o !== we0) ||
            (wbm_stb_o !== 1'b1) || (wbm_sel_o !== 4'hF)) unstable = 1'b1;
        len++;
      end else if (len > 0) begin
        if (have) begin
          if (cur.kind == 0) chk("cyc_len", 32'(len), 32'(cur.delay + 1));
          else if (cur.kind == 1) chk("cyc_len_timeout", 32'(len), 32'(ACK_TIMEOUT));
          chk("bus_hold_stable", 32'(unstable), 32'h0);
        end
        len = 0; have = 1'b0; unstable = 1'b0;
      end

      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom();
      if (wbm_cyc_o) begin
        if (!slave_mute && (cnt >= slave_delay)) begin
          wbm_ack_i = 1'b1;
          if (wbm_we_o) slave_mem[wbm_adr_o] = wbm_dat_o;
          else wbm_dat_i = slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o] : dflt(wbm_adr_o);
        end
        cnt++;
      end else begin
        cnt = 0;
        // stray acks outside a bus cycle must be ignored
        if ($urandom_range(0, 7) == 0) wbm_ack_i = 1'b1;
      end
    end
  end

  // UART transmitter sink and response monitor
  initial begin : tx_sink
    bit       prev_wait;
    bit [7:0] prev_data;
    bit [7:0] e;
    prev_wait = 1'b0; prev_data = 8'h0;
    tx_ready = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (overrun_o) obs_ovr++;
      if (prev_wait && tx_valid) chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
      if (tx_valid && (tx_hold > 0)) begin
        tx_ready = 1'b0;
        tx_hold--;
      end else begin
        tx_ready = ($urandom_range(0, 2) != 0);
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_byte: got 0x%0h, expected none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
      end
      prev_wait = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  // All tasks start and end just after a falling edge
  task automatic send_byte(input bit [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge wb_clk_i);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom());
    repeat (gap) @(negedge wb_clk_i);
  endtask

  task automatic send_frame(input bit we, input bit [31:0] adr, input bit [31:0] dat);
    send_byte(we ? 8'h57 : 8'h52, $urandom_range(0, 3));
    for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], (!we && i == 0) ? 0 : $urandom_range(0, 3));
    if (we) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], (i == 0) ? 0 : $urandom_range(0, 3));
  endtask

  task automatic wait_done(input bit ovr);
    int n;
    bit injected;
    n = 0; injected = 1'b0;
    while (busy_o && n < 400) begin
      if (ovr && !injected && wbm_cyc_o) begin
        injected = 1'b1;
        exp_ovr++;
        send_byte(8'($urandom()), 0);
      end else begin
        @(negedge wb_clk_i);
      end
      n++;
    end
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy_o=%0b after %0d cycles, expected 0", busy_o, n);
    end
    repeat (2) @(negedge wb_clk_i);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
    chk("overrun_count", 32'(obs_ovr), 32'(exp_ovr));
    chk("busy_idle", 32'(busy_o), 32'h0);
  endtask

  // Expected outcome comes from the command itself and the model memory
  task automatic issue(input bit we, input bit [31:0] adr, input bit [31:0] dat,
                       input int delay, input bit mute, input bit ovr);
    bus_exp_t  e;
    bit [31:0] rv;
    e.we = we; e.adr = adr; e.dat = dat; e.kind = mute ? 1 : 0; e.delay = delay;
    exp_bus.push_back(e);
    if (mute) begin
      exp_tx.push_back(8'h45);
    end else if (we) begin
      exp_tx.push_back(8'h4B);
      model_mem[adr] = dat;
    end else begin
      rv = model_mem.exists(adr) ? model_mem[adr] : dflt(adr);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rv[8*i +: 8]);
    end
    slave_delay = delay;
    slave_mute  = mute;
    send_frame(we, adr, dat);
    wait_done(ovr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({tx_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, overrun_o}), 32'h0);
    chk({tag, "_adr"}, wbm_adr_o, 32'h0);
    chk({tag, "_dat"}, wbm_dat_o, 32'h0);
    chk({tag, "_txd"}, 32'(tx_data), 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    bus_exp_t ab;
    int       n;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check_all_zero("reset");
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Directed write, ack after 3 bus cycles
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);

    // Directed read with a stalled transmitter
    slave_mem[32'h3000_0000] = 32'h1234_5678;
    model_mem[32'h3000_0000] = 32'h1234_5678;
    tx_hold = 5;
    issue(1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 1'b0);

    // Ack timeout, then a normal frame
    issue(1'b0, 32'h3000_0010, 32'h0, 0, 1'b1, 1'b0);
    issue(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 1, 1'b0, 1'b0);

    // Partial frame abandoned by a long gap
    send_byte(8'h57, 0);
    send_byte(8'h30, 0);
    send_byte(8'h00, 20);
    issue(1'b0, 32'h3000_0004, 32'h0, 1, 1'b0, 1'b0);

    // New command byte arriving exactly on the gap-expiry cycle
    send_byte(8'h57, 0);
    send_byte(8'h30, FRAME_GAP);
    issue(1'b0, 32'h3000_0010, 32'h0, 0, 1'b0, 1'b0);

    // Non-command bytes in IDLE
    foreach (exp_tx[i]) exp_tx.delete(i);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 0) ? 8'hFF : ((i == 1) ? 8'h00 : 8'h11);
      @(negedge wb_clk_i);
      rx_valid = 1'b0;
      chk("busy_after_garbage", 32'(busy_o), 32'h0);
    end

    // Overrun injected during the bus cycle of a write
    issue(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 3, 1'b0, 1'b1);

    // Reset while the bus cycle is outstanding
    ab.we = 1'b0; ab.adr = 32'h3000_0008; ab.dat = 32'h0; ab.kind = 2; ab.delay = 0;
    exp_bus.push_back(ab);
    slave_mute = 1'b1;
    send_frame(1'b0, 32'h3000_0008, 32'h0);
    n = 0;
    while (!wbm_cyc_o && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("cyc_before_reset", 32'(wbm_cyc_o), 32'h1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_all_zero("mid_reset");
    wb_rst_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    chk("reset_no_bus_pending", 32'(exp_bus.size()), 32'h0);
    issue(1'b0, 32'h3000_0008, 32'h0, 2, 1'b0, 1'b0);

    // Randomized commands over a small address window
    for (int k = 0; k < 40; k++) begin
      issue($urandom_range(0, 1) == 1,
            32'h3000_0000 + 32'(4 * $urandom_range(0, 7)),
            $urandom(),
            $urandom_range(0, 4),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
Host-side command bridge. Turns a UART byte stream into Wishbone master cycles that target the user-project register space at 0x3000_0000. Sits between a UART receiver/transmitter pair (byte-level interfaces) and the Wishbone bus. It lets an external host read and write the UART control block and other user slaves without the CPU.

Parameters:
ACK_TIMEOUT, 255, max cycles cyc/stb stay asserted waiting for ack before abort (1..65535)
FRAME_GAP, 4000, max idle cycles between bytes of one command frame before it is discarded (1..2^20-1)

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte (no backpressure)
rx_data  input  8  received byte
tx_valid  output  1  tx_data valid toward UART transmitter
tx_data  output  8  response byte
tx_ready  input  1  transmitter accepts byte; transfer when tx_valid && tx_ready at posedge
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe (always equal to wbm_cyc_o)
wbm_we_o  output  1  write enable
wbm_sel_o  output  4  byte select, always 4'hF during a cycle
wbm_adr_o  output  32  address
wbm_dat_o  output  32  write data
wbm_ack_i  input  1  slave acknowledge
wbm_dat_i  input  32  read data
busy_o  output  1  high in any state other than IDLE
overrun_o  output  1  one-cycle pulse: rx byte dropped (arrived in WB or RESP)

Behaviour:
- Reset (wb_clk_i edge with wb_rst_i=1): state IDLE; all outputs 0, including tx_data, wbm_adr_o, wbm_dat_o, wbm_sel_o; byte counters and timers cleared. Reset mid-cycle drops cyc/stb the next edge, with no response.
- Frame format, MSB-first: 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0; 'R'(0x52) A3 A2 A1 A0.
- Response: write OK -> 0x4B ('K'); read OK -> D3 D2 D1 D0; timeout -> 0x45 ('E'), single byte for both read and write.
- States:
  - IDLE: on rx_valid with 0x57/0x52, latch we and go to ADDR. Any other byte is ignored silently and the state stays IDLE.
  - ADDR: shift 4 bytes into the address register. After the 4th byte go to DATA (write) or WB (read).
  - DATA: shift 4 bytes into the write-data register, then go to WB.
  - WB: cyc/stb/sel asserted on the edge after the last frame byte is accepted, so the first bus cycle is 1 cycle later. Hold adr/dat/we stable.
    - At the first edge where wbm_ack_i=1: deassert cyc/stb at that edge, capture wbm_dat_i if reading, go to RESP.
    - If ACK_TIMEOUT edges pass with no ack: deassert cyc/stb, set error flag, go to RESP.
  - RESP: tx_valid=1 the cycle after entering RESP. tx_data is stable while tx_valid && !tx_ready. After each accepted byte, the next byte is presented the following cycle (tx_valid may stay high). After the last byte is accepted, tx_valid=0 and state returns to IDLE.
- Gap timer: runs only in ADDR/DATA and resets on every rx_valid. When it reaches FRAME_GAP, the partial frame is discarded and the state returns to IDLE with no response.
- A byte arriving in the same cycle the gap limit hits is treated as the first byte of a new frame in IDLE.
- rx_valid during WB or RESP: byte dropped and overrun_o pulses for 1 cycle. Frame processing is unaffected.
- An ack that arrives on the same edge the timeout expires counts as success.
- wbm_ack_i is ignored outside WB.
- No pipelining: one outstanding bus cycle at most. There is no burst support.
- Address is passed unmodified; no alignment or range check is done.

Test Plan:
- Write: rx bytes 57 30 00 00 04 DE AD BE EF -> exactly one cycle with adr=0x30000004, dat=0xDEADBEEF, we=1, sel=F; slave acks after 3 cycles -> tx byte 0x4B, then busy_o=0.
- Read: rx 52 30 00 00 00; slave returns 0x12345678 with 1-cycle ack; tx_ready held low 5 cycles -> tx_data holds 0x12 and stays stable; then bytes 12 34 56 78 are sent in order and the bridge returns to IDLE.
- Timeout: ACK_TIMEOUT=8, read with no ack -> cyc deasserts after 8 edges; single tx byte 0x45; next frame processes normally.
- Frame gap: FRAME_GAP=16, send 57 30 00 then wait 20 cycles, then send a full read frame -> no bus cycle for the partial write; the read completes correctly.
- Garbage and overrun: bytes FF 00 11 in IDLE are ignored (busy_o stays 0). A byte injected during WB pulses overrun_o once, and the write still answers 0x4B.
- Reset mid-cycle: assert wb_rst_i while cyc=1 -> all outputs 0 next edge; no tx byte is sent; a new frame afterwards works.
